// File: rtl/multiplier_unit.sv
// multiplier_unit: pipelined RV32M MUL/MULH/MULHSU/MULHU execution unit.
// Latency: STAGES cycles from operand capture to result_o/done_o (STAGES >= 4).
// Backpressure: none; a new operation may be accepted on every cycle.
module multiplier_unit #(
    parameter int STAGES = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [6:0]  opcode_i,
    input  logic [2:0]  funct3_i,
    input  logic [6:0]  funct7_i,
    input  logic [31:0] op_A_i,
    input  logic [31:0] op_B_i,
    output logic [31:0] result_o,
    output logic        done_o
);

    // Operands are held as 17-bit unsigned low halves and 16-bit signed high
    // halves of the 33-bit extended values: value = hi * 2^17 + lo.
    typedef struct packed {
        logic [16:0] a_lo;
        logic [15:0] a_hi;
        logic [16:0] b_lo;
        logic [15:0] b_hi;
        logic        upper;
    } op_t;

    typedef struct packed {
        logic [33:0] ll;
        logic [33:0] lh;
        logic [33:0] hl;
        logic [31:0] hh;
        logic        upper;
    } pp_t;

    typedef struct packed {
        logic [63:0] prod;
        logic        upper;
    } sum_t;

    logic        mult_on;
    logic        signed_a;
    logic        signed_b;
    logic        upper;
    logic [32:0] a_ext;
    logic [32:0] b_ext;
    op_t         op_d;
    op_t         op_q;
    logic        op_vld;
    pp_t         pp_d;
    pp_t         pp_q;
    logic        pp_vld;
    logic [63:0] sum_d;
    sum_t        sum_q   [3:STAGES-1];
    logic [STAGES-1:3] sum_vld;

    always_comb begin
        mult_on  = (opcode_i == 7'b0110011) && (funct7_i == 7'b0000001) && !funct3_i[2];
        signed_a = (funct3_i[1:0] == 2'b01) || (funct3_i[1:0] == 2'b10);
        signed_b = (funct3_i[1:0] == 2'b01);
        upper    = (funct3_i[1:0] != 2'b00);
        a_ext    = {signed_a & op_A_i[31], op_A_i};
        b_ext    = {signed_b & op_B_i[31], op_B_i};
        op_d.a_lo  = a_ext[16:0];
        op_d.a_hi  = a_ext[32:17];
        op_d.b_lo  = b_ext[16:0];
        op_d.b_hi  = b_ext[32:17];
        op_d.upper = upper;
    end

    // Operands are sign-extended to the product width, so the low bits of an
    // unsigned multiply equal the exact signed partial product.
    always_comb begin
        pp_d.ll    = {17'b0, op_q.a_lo} * {17'b0, op_q.b_lo};
        pp_d.lh    = {17'b0, op_q.a_lo} * {{18{op_q.b_hi[15]}}, op_q.b_hi};
        pp_d.hl    = {{18{op_q.a_hi[15]}}, op_q.a_hi} * {17'b0, op_q.b_lo};
        pp_d.hh    = {{16{op_q.a_hi[15]}}, op_q.a_hi} * {{16{op_q.b_hi[15]}}, op_q.b_hi};
        pp_d.upper = op_q.upper;
    end

    always_comb begin
        sum_d = {30'b0, pp_q.ll}
              + ({{30{pp_q.lh[33]}}, pp_q.lh} << 17)
              + ({{30{pp_q.hl[33]}}, pp_q.hl} << 17)
              + {pp_q.hh[29:0], 34'b0};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q   <= '0;
            op_vld <= 1'b0;
            pp_q   <= '0;
            pp_vld <= 1'b0;
        end else begin
            op_vld <= mult_on;
            if (mult_on) begin
                op_q <= op_d;
            end
            pp_vld <= op_vld;
            pp_q   <= pp_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 3; i < STAGES; i++) begin
                sum_q[i] <= '0;
            end
            sum_vld <= '0;
        end else begin
            sum_q[3].prod  <= sum_d;
            sum_q[3].upper <= pp_q.upper;
            sum_vld[3]     <= pp_vld;
            for (int i = 4; i < STAGES; i++) begin
                sum_q[i]   <= sum_q[i-1];
                sum_vld[i] <= sum_vld[i-1];
            end
        end
    end

    // result_o keeps the last completed value between completions.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            result_o <= '0;
            done_o   <= 1'b0;
        end else begin
            done_o <= sum_vld[STAGES-1];
            if (sum_vld[STAGES-1]) begin
                result_o <= sum_q[STAGES-1].upper ? sum_q[STAGES-1].prod[63:32]
                                                  : sum_q[STAGES-1].prod[31:0];
            end
        end
    end

endmodule

// File: tb/tb_multiplier_unit.sv
// Bench for multiplier_unit: directed RV32M vectors, random traffic and
// mid-flight reset, checked against a 64-bit arithmetic reference model.
module tb_multiplier_unit;

    localparam int STAGES = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [6:0]  opcode_i;
    logic [2:0]  funct3_i;
    logic [6:0]  funct7_i;
    logic [31:0] op_A_i;
    logic [31:0] op_B_i;
    logic [31:0] result_o;
    logic        done_o;

    multiplier_unit #(.STAGES(STAGES)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .opcode_i (opcode_i),
        .funct3_i (funct3_i),
        .funct7_i (funct7_i),
        .op_A_i   (op_A_i),
        .op_B_i   (op_B_i),
        .result_o (result_o),
        .done_o   (done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic        vld;
        logic [31:0] res;
    } exp_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        pipe_q[$];
    logic [31:0] last_res;
    logic [31:0] corners [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // RV32M semantics: extend to 64 bits per signedness, multiply, pick a word.
    function automatic logic [31:0] ref_mul(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [63:0] ea, eb, p;
        logic sa, sb;
        sa = (f3 == 3'd1) || (f3 == 3'd2);
        sb = (f3 == 3'd1);
        ea = sa ? {{32{a[31]}}, a} : {32'b0, a};
        eb = sb ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ea * eb;
        return (f3 == 3'd0) ? p[31:0] : p[63:32];
    endfunction

    task automatic model_reset();
        pipe_q.delete();
        for (int i = 0; i < STAGES - 1; i++) pipe_q.push_back('0);
        last_res = '0;
    endtask

    task automatic step(input string tag, input logic [6:0] opc, input logic [6:0] f7,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        exp_t e, d;
        opcode_i = opc;
        funct7_i = f7;
        funct3_i = f3;
        op_A_i   = a;
        op_B_i   = b;
        e.vld = (opc == 7'h33) && (f7 == 7'h01) && (f3 < 3'd4);
        e.res = ref_mul(f3, a, b);
        pipe_q.push_back(e);
        @(posedge clk_i);
        #1;
        d = pipe_q.pop_front();
        if (d.vld) last_res = d.res;
        check({tag, "_done"}, {31'b0, done_o}, {31'b0, d.vld});
        check({tag, "_result"}, result_o, last_res);
    endtask

    task automatic mul(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        step("mul", 7'h33, 7'h01, f3, a, b);
    endtask

    task automatic idle();
        step("idle", 7'h00, 7'h00, 3'd0, $urandom, $urandom);
    endtask

    task automatic run_const(input string tag, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] expv);
        mul(f3, a, b);
        repeat (STAGES - 1) idle();
        check({tag, "_const"}, result_o, expv);
        check({tag, "_pulse"}, {31'b0, done_o}, 32'd1);
    endtask

    function automatic logic [31:0] pick_operand();
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        rst_i    = 1'b1;
        opcode_i = '0;
        funct3_i = '0;
        funct7_i = '0;
        op_A_i   = '0;
        op_B_i   = '0;
        #3;
        check("reset_result", result_o, 32'h0);
        check("reset_done", {31'b0, done_o}, 32'd0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        model_reset();

        run_const("mul_a", 3'd0, 32'h80000001, 32'h80010002, 32'h80010002);
        run_const("mulh_a", 3'd1, 32'h80000001, 32'h80010002, 32'h3FFF7FFE);
        run_const("mulhsu_a", 3'd2, 32'h80000001, 32'h80010002, 32'hBFFF7FFF);
        run_const("mulhu_a", 3'd3, 32'h80000001, 32'h80010002, 32'h40008001);
        run_const("mulh_m1", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
        run_const("mulhu_m1", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run_const("mulhsu_m1", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_const("mul_m1", 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);

        // Back-to-back issue: two consecutive completions.
        mul(3'd0, 32'd9, 32'd7);
        mul(3'd3, 32'h80000001, 32'h80010002);
        repeat (STAGES - 2) idle();
        check("b2b_first", result_o, 32'h0000003F);
        check("b2b_first_done", {31'b0, done_o}, 32'd1);
        idle();
        check("b2b_second", result_o, 32'h40008001);
        check("b2b_second_done", {31'b0, done_o}, 32'd1);
        idle();
        check("b2b_after_done", {31'b0, done_o}, 32'd0);

        // Non-multiply encodings must neither pulse nor disturb the result.
        step("div_class", 7'h33, 7'h01, 3'd4, 32'd5, 32'd6);
        for (int f = 0; f < 8; f++) step("f7_zero", 7'h33, 7'h00, 3'(f), $urandom, $urandom);
        repeat (STAGES) idle();
        check("nonmul_hold", result_o, 32'h40008001);

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0:       idle();
                1:       step("rand_bad", 7'h33, 7'h00, 3'($urandom_range(0, 7)),
                              pick_operand(), pick_operand());
                2:       step("rand_opc", 7'h13, 7'h01, 3'($urandom_range(0, 3)),
                              pick_operand(), pick_operand());
                default: mul(3'($urandom_range(0, 7)), pick_operand(), pick_operand());
            endcase
        end
        repeat (STAGES) idle();

        // Reset two cycles after issue discards the in-flight operation.
        mul(3'd0, 32'd123, 32'd456);
        idle();
        idle();
        #2;
        rst_i = 1'b1;
        #1;
        check("midrst_result", result_o, 32'h0);
        check("midrst_done", {31'b0, done_o}, 32'd0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        model_reset();
        repeat (STAGES + 2) idle();
        run_const("post_rst", 3'd0, 32'd9, 32'd7, 32'h0000003F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multiplier_unit.md
MULTIPLIER_UNIT -- requirements
Module: multiplier_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk_i  in  1  clock, all state updates on the rising edge.
REQ-002 rst_i  in  1  asynchronous, active-high reset.
REQ-003 opcode_i  in  7  instruction opcode field.
REQ-004 funct3_i  in  3  instruction funct3 field.
REQ-005 funct7_i  in  7  instruction funct7 field.
REQ-006 op_A_i  in  32  rs1 operand.
REQ-007 op_B_i  in  32  rs2 operand.
REQ-008 result_o  out  32  result of the most recently completed multiply.
REQ-009 done_o  out  1  one-cycle pulse marking a newly completed result.
REQ-010 The parameter STAGES SHALL default to 4 and set the pipeline latency in clock cycles.

Function
REQ-011 The decode SHALL be combinational: mult_on = (opcode_i==7'b0110011) && (funct7_i==7'b0000001) && (funct3_i[2]==0).
REQ-012 The decode SHALL map funct3 as follows:
- 000 MUL: A unsigned, B unsigned, lower word.
- 001 MULH: A signed, B signed, upper word.
- 010 MULHSU: A signed, B unsigned, upper word.
- 011 MULHU: A unsigned, B unsigned, upper word.
REQ-013 Any other encoding, including funct3[2]=1 (divide class), SHALL give mult_on=0, and no operation SHALL be started.
REQ-014 On each rising edge with mult_on=1, the block SHALL capture op_A_i, op_B_i, signed_A, signed_B and upper into pipeline stage 1.
REQ-015 A new operation MAY be issued every cycle (fully pipelined), with no stall or backpressure.
REQ-016 Arithmetic SHALL sign- or zero-extend each operand to 33 bits according to its signed flag, then form a signed 33x33 product.
REQ-017 The low 64 bits of the product SHALL be bit-exact to the RV32M definition, with no rounding or saturation.
REQ-018 result_o SHALL be product[31:0] when upper=0 and product[63:32] when upper=1.
REQ-019 Latency SHALL be exactly STAGES cycles: an operation captured at edge k updates result_o and asserts done_o after edge k+STAGES-1, so both are visible in the cycle following that edge.
REQ-020 Partial-product generation and accumulation SHALL be split across the STAGES register stages (e.g. 17-bit operand halves, one partial-product group per stage).
REQ-021 A valid bit SHALL travel alongside each operation through the pipeline.
REQ-022 done_o SHALL be high for exactly one cycle per completed operation, or continuously when operations are issued back to back.
REQ-023 result_o SHALL hold its last completed value while no operation completes.
REQ-024 Operations SHALL complete in issue order, and the flags of each operation SHALL travel with it.
REQ-025 Input changes after capture SHALL NOT affect operations already in flight.

Reset
REQ-026 While rst_i=1, result_o SHALL be 0, done_o SHALL be 0, and every pipeline valid bit SHALL be 0, asynchronously.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight operations, and no done_o pulse SHALL appear for them after release.
REQ-028 The first operation captured on or after the first rising edge following reset release SHALL complete with normal latency.

Verification
REQ-029 MUL, A=0x80000001, B=0x80010002 -> result_o=0x80010002 and done_o=1, STAGES cycles after capture.
REQ-030 Same operands, MULH -> result_o=0x3FFF7FFE; MULHSU -> result_o=0xBFFF7FFF; MULHU -> result_o=0x40008001.
REQ-031 A=B=0xFFFFFFFF: MULH -> 0x00000000, MULHU -> 0xFFFFFFFE, MULHSU -> 0xFFFFFFFF, MUL -> 0x00000001.
REQ-032 Back-to-back issue of MUL 9x7 then MULHU 0x80000001x0x80010002 on consecutive cycles -> consecutive outputs 0x0000003F then 0x40008001, with done_o high for 2 consecutive cycles.
REQ-033 funct7=0000001 with funct3=100, or funct7=0000000 with any funct3 -> no done_o pulse and result_o unchanged.
REQ-034 Issue MUL, then assert rst_i 2 cycles later -> result_o=0 and done_o=0 immediately, and no pulse appears after release.
